// File: rtl/core_irq_ctl_if.sv
`default_nettype none
// ============================================================================
// core_irq_ctl_if : request lines, boundary strobe and vector outputs shared
//                   between the CPU core and its interrupt controller.
// Revision        : 1.0
// ============================================================================
interface core_irq_ctl_if #(
  parameter int CHANNELS = 3
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                I_ready;
  logic [CHANNELS-1:0] I_src;
  logic                I_sync;
  logic                I_mask;
  logic                O_force_brk;
  logic                O_soft_brk;
  logic [CW-1:0]       O_chan;
  logic [15:0]         O_vec_lo;
  logic [15:0]         O_vec_hi;
  logic [CHANNELS-1:0] O_raised;

  modport master (
    output I_ready, I_src, I_sync, I_mask,
    input  O_force_brk, O_soft_brk, O_chan, O_vec_lo, O_vec_hi, O_raised
  );

  modport slave (
    input  I_ready, I_src, I_sync, I_mask,
    output O_force_brk, O_soft_brk, O_chan, O_vec_lo, O_vec_hi, O_raised
  );
endinterface
`default_nettype wire

// File: rtl/core_irq_ctl.sv
`default_nettype none
// ============================================================================
// core_irq_ctl : latches edge/level interrupt requests, picks the highest
//                priority eligible one at each instruction boundary.
// Revision     : 1.0
// ============================================================================
module core_irq_ctl #(
  parameter int                     CHANNELS    = 3,
  parameter logic [CHANNELS-1:0]    EDGE_MASK   = 3'b011,
  parameter logic [CHANNELS-1:0]    NOMASK_MASK = 3'b011,
  parameter logic [CHANNELS-1:0]    RESET_RAISE = 3'b001,
  parameter logic [CHANNELS*16-1:0] VEC_TABLE   = {16'hFFFE, 16'hFFFA, 16'hFFFC},
  parameter logic [15:0]            SOFT_VEC    = 16'hFFFE
) (
  input  logic           I_clock,
  input  logic           I_reset,
  core_irq_ctl_if.slave  bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] r_raise;
  logic [CHANNELS-1:0] r_last_src;
  logic [CHANNELS-1:0] r_pend;
  logic                r_last_sync;

  logic                w_sync_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_raise;
  logic [CHANNELS-1:0] w_elig;
  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_raise_nxt;
  logic [CW-1:0]       w_chan;
  logic [15:0]         w_vec;

  assign w_sync_rise = bus.I_sync & ~r_last_sync;
  assign w_fall      = r_last_src & ~bus.I_src & EDGE_MASK;

  // Edge channels come from the sticky register, level channels straight from the pin.
  assign w_raise = (r_raise & EDGE_MASK) | (~bus.I_src & ~EDGE_MASK);
  assign w_elig  = w_raise & (NOMASK_MASK | {CHANNELS{~bus.I_mask}});

  always_comb begin
    w_sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  // A fresh falling edge in the consuming cycle re-arms the channel.
  assign w_clr       = w_sync_rise ? (w_sel & EDGE_MASK) : '0;
  assign w_raise_nxt = ((r_raise & ~w_clr) | w_fall) & EDGE_MASK;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_raise     <= RESET_RAISE & EDGE_MASK;
      r_last_src  <= '1;
      r_last_sync <= 1'b0;
      r_pend      <= '0;
    end else if (bus.I_ready) begin
      r_raise     <= w_raise_nxt;
      r_last_src  <= bus.I_src;
      r_last_sync <= bus.I_sync;
      if (w_sync_rise) begin
        r_pend <= w_sel;
      end
    end
  end

  always_comb begin
    w_chan = '0;
    w_vec  = SOFT_VEC;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_pend[i]) begin
        w_chan = CW'(i);
        w_vec  = VEC_TABLE[16*i +: 16];
      end
    end
  end

  assign bus.O_force_brk = |r_pend;
  assign bus.O_soft_brk  = ~(|r_pend);
  assign bus.O_chan      = w_chan;
  assign bus.O_vec_lo    = w_vec;
  assign bus.O_vec_hi    = w_vec + 16'd1;
  assign bus.O_raised    = w_raise;
endmodule
`default_nettype wire

// File: tb/tb_core_irq_ctl.sv
`default_nettype none
// ============================================================================
// tb_core_irq_ctl : directed scenarios plus random traffic against a
//                   behavioural interrupt model.
// Revision        : 1.0
// ============================================================================
module tb_core_irq_ctl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_irq_ctl_if #(.CHANNELS(3)) bus ();

  core_irq_ctl dut (
    .I_clock (clk),
    .I_reset (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: per-channel properties and state as plain arrays.
  bit          is_edge[3] = '{1'b1, 1'b1, 1'b0};
  bit          no_mask[3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] vec_of[3]  = '{16'hFFFC, 16'hFFFA, 16'hFFFE};
  bit          m_raise[3];
  bit          m_last_src[3];
  bit          m_last_sync;
  int          m_pend;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit seen_raise(int i);
    if (is_edge[i]) return m_raise[i];
    return !bus.I_src[i];
  endfunction

  task automatic model_reset();
    m_raise     = '{1'b1, 1'b0, 1'b0};
    m_last_src  = '{1'b1, 1'b1, 1'b1};
    m_last_sync = 1'b0;
    m_pend      = -1;
  endtask

  task automatic model_clock();
    int chosen;
    chosen = -1;
    if (bus.I_sync && !m_last_sync) begin
      for (int i = 0; i < 3; i++)
        if (chosen < 0 && seen_raise(i) && (no_mask[i] || !bus.I_mask)) chosen = i;
      m_pend = chosen;
    end
    for (int i = 0; i < 3; i++) begin
      if (is_edge[i]) begin
        if (chosen == i) m_raise[i] = 1'b0;
        if (m_last_src[i] && !bus.I_src[i]) m_raise[i] = 1'b1;
      end
      m_last_src[i] = bus.I_src[i];
    end
    m_last_sync = bus.I_sync;
  endtask

  task automatic compare_all();
    logic [15:0] ev;
    logic [2:0]  er;
    ev = (m_pend >= 0) ? vec_of[m_pend] : 16'hFFFE;
    for (int i = 0; i < 3; i++) er[i] = seen_raise(i);
    check_value("force_brk", bus.O_force_brk, m_pend >= 0);
    check_value("soft_brk",  bus.O_soft_brk,  m_pend < 0);
    check_value("chan",      bus.O_chan,      (m_pend >= 0) ? m_pend : 0);
    check_value("vec_lo",    bus.O_vec_lo,    ev);
    check_value("vec_hi",    bus.O_vec_hi,    ev + 16'd1);
    check_value("raised",    bus.O_raised,    er);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && bus.I_ready) model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rise();
    bus.I_sync = 1'b1;
    step();
  endtask

  task automatic fall();
    bus.I_sync = 1'b0;
    step();
  endtask

  initial begin
    bus.I_ready = 1'b1;
    bus.I_src   = 3'b111;
    bus.I_sync  = 1'b0;
    bus.I_mask  = 1'b1;
    model_reset();
    repeat (3) step();
    check_value("rst_vec", bus.O_vec_lo, 16'hFFFE);
    check_value("rst_raised", bus.O_raised, 3'b001);

    // Reset request serviced at the first boundary
    rst_n = 1'b1;
    repeat (2) step();
    rise();
    check_value("p1_force", bus.O_force_brk, 1'b1);
    check_value("p1_chan", bus.O_chan, 2'd0);
    check_value("p1_vec", bus.O_vec_lo, 16'hFFFC);
    check_value("p1_vechi", bus.O_vec_hi, 16'hFFFD);
    check_value("p1_soft", bus.O_soft_brk, 1'b0);
    fall();
    rise();
    check_value("p1_idle_force", bus.O_force_brk, 1'b0);
    check_value("p1_idle_vec", bus.O_vec_lo, 16'hFFFE);
    fall();

    // NMI edge ignores mask
    bus.I_src = 3'b101;
    repeat (2) step();
    bus.I_src = 3'b111;
    repeat (3) step();
    rise();
    check_value("p2_chan", bus.O_chan, 2'd1);
    check_value("p2_vec", bus.O_vec_lo, 16'hFFFA);
    check_value("p2_raised1", bus.O_raised[1], 1'b0);
    fall();

    // Maskable level request
    bus.I_src = 3'b011;
    step();
    rise();
    check_value("p3_masked", bus.O_force_brk, 1'b0);
    fall();
    bus.I_mask = 1'b0;
    step();
    rise();
    check_value("p3_chan", bus.O_chan, 2'd2);
    check_value("p3_vec", bus.O_vec_lo, 16'hFFFE);
    fall();
    bus.I_src = 3'b111;
    step();
    rise();
    check_value("p3_dropped", bus.O_force_brk, 1'b0);
    fall();

    // Priority: edge ch1 over level ch2
    bus.I_src = 3'b001;
    step();
    bus.I_src = 3'b011;
    step();
    rise();
    check_value("p4_first", bus.O_chan, 2'd1);
    fall();
    rise();
    check_value("p4_second", bus.O_chan, 2'd2);
    fall();
    bus.I_src = 3'b111;
    step();

    // New edge on ch1 in its consuming cycle
    bus.I_mask = 1'b1;
    bus.I_src = 3'b101;
    step();
    bus.I_src = 3'b111;
    step();
    bus.I_src  = 3'b101;
    bus.I_sync = 1'b1;
    step();
    check_value("p5_chan", bus.O_chan, 2'd1);
    check_value("p5_raised1", bus.O_raised[1], 1'b1);
    bus.I_src  = 3'b111;
    bus.I_sync = 1'b0;
    step();
    rise();
    check_value("p5_again", bus.O_chan, 2'd1);
    check_value("p5_again_f", bus.O_force_brk, 1'b1);
    fall();
    rise();
    check_value("p5_idle", bus.O_force_brk, 1'b0);
    fall();

    // Clock enable hold, then async reset mid-service
    bus.I_src = 3'b110;
    step();
    bus.I_src = 3'b111;
    step();
    rise();
    check_value("p6_chan0", bus.O_vec_lo, 16'hFFFC);
    fall();
    bus.I_ready = 1'b0;
    bus.I_src = 3'b101;
    step();
    bus.I_sync = 1'b1;
    step();
    check_value("p6_hold_force", bus.O_force_brk, 1'b1);
    check_value("p6_hold_raised", bus.O_raised, 3'b000);
    bus.I_sync = 1'b0;
    bus.I_src = 3'b111;
    step();
    bus.I_ready = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_value("p6_rst_force", bus.O_force_brk, 1'b0);
    check_value("p6_rst_raised", bus.O_raised, 3'b001);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 3) == 0) bus.I_src[i] = ~bus.I_src[i];
      if ($urandom_range(0, 2) == 0) bus.I_sync = ~bus.I_sync;
      if ($urandom_range(0, 7) == 0) bus.I_mask = ~bus.I_mask;
      bus.I_ready = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
